pipe_rr_scheduler: RTL and testbench
====================================

Name: pipe_rr_scheduler

Overview:
- Shares one fixed-latency, clock-enabled datapath pipeline among NUM_REQ requesters. Typical datapaths are the multiply/interpolate units in the shader path, built from enable-gated delay stages.
- Arbitrates round-robin and drives the pipeline's input and its global clock enable.
- Tracks requester IDs through a matching tag delay line, so each result returns to its originator.
- Stalls the whole pipeline when the head result is not accepted.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_W, 32, width of request operand and pipeline result.
- LATENCY, 4, number of enabled clock edges from pipe_in to pipe_out (>=1).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_data  input  NUM_REQ x DATA_W  per-requester operand.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- pipe_clk_en  output  1  clock enable for every flop of the shared pipeline.
- pipe_in  output  DATA_W  operand to the pipeline.
- pipe_out  input  DATA_W  pipeline result; corresponds to pipe_in from LATENCY enabled edges earlier.
- resp_valid  output  NUM_REQ  per-requester result valid; one-hot or zero.
- resp_data  output  DATA_W  result, shared by all requesters; equals pipe_out.
- resp_ready  input  NUM_REQ  per-requester result accept.
- inflight  output  $clog2(LATENCY+1)  count of valid tags in the tag line.

Behaviour:
- Tag line: LATENCY stages of {valid, id[$clog2(NUM_REQ)]}.
  - Stage LATENCY-1 is the entry; stage 0 is the head, aligned with pipe_out.
  - Advances only on edges where pipe_clk_en=1.
- head_valid = stage0.valid.
- stall = head_valid & ~resp_ready[stage0.id].
- pipe_clk_en = ~stall (combinational). Bubbles are not collapsed; the pipeline moves as a rigid unit.
- Grant (combinational): search req_valid starting at rr_ptr, wrapping modulo NUM_REQ; the first set bit wins.
- req_ready[g] = grant_valid & ~stall for the granted g only; all other bits are 0.
- Issue occurs when req_valid[g] & req_ready[g]. On issue:
  - pipe_in = req_data[g].
  - Entry tag = {1, g}.
  - rr_ptr <= (g+1) mod NUM_REQ.
- No issue and ~stall: pipe_in = 0, entry tag = {0, 0}, rr_ptr unchanged.
- Stall: tag line and rr_ptr hold. pipe_in is don't-care; drive 0.
- Response outputs:
  - resp_valid[i] = head_valid & (stage0.id == i).
  - resp_data = pipe_out.
  - A response is consumed on the edge where resp_valid[i] & resp_ready[i]. The head advances that same edge.
- Latency: a request issued at edge k gives resp_valid high in the cycle after edge k+LATENCY-1, i.e. LATENCY edges later with no stall. Each stall cycle adds one cycle.
- Throughput: 1 result per cycle with resp_ready held high.
- Simultaneous head-accept and issue on the same edge is allowed and required for full throughput.
- inflight: registered.
  - +1 on issue, -1 on head consumption, unchanged on both or neither.
  - Never exceeds LATENCY.
- Combinational path resp_ready -> pipe_clk_en -> req_ready is intentional and documented. Requesters must not make req_valid depend on req_ready.
- Requesters hold req_valid/req_data until accepted. The grant may move to another requester while it is unaccepted (e.g. a stall clears with a new lower-pointer request); a held request is still served within NUM_REQ issues.
- Reset (async, any time, including mid-operation):
  - All tag valids = 0, rr_ptr = 0, inflight = 0.
  - Hence resp_valid = 0 and pipe_clk_en = 1.
  - req_ready follows the grant logic.
  - The shared pipeline is reset by the same rst. Results in flight are discarded and never reported.
- Non-power-of-2 NUM_REQ: rr_ptr wraps from NUM_REQ-1 to 0; ids >= NUM_REQ never occur.

Decomposition:
- Package pipe_sched_pkg:
  - localparam helper ID_W(NUM_REQ) = max(1, $clog2(NUM_REQ)).
  - typedef struct packed {logic valid; logic [ID_W-1:0] id;} sched_tag_t.
- Sub-module rr_grant:
  - Combinational round-robin picker: req vector + pointer -> grant_valid, grant index.
  - Reusable by the other arbiters in the design.
- Tag line: inline register array in the top, not a separate module.

Test Plan:
- Single request, LATENCY=4: req0 valid with data 0x11, resp_ready all 1 → req_ready[0]=1 on the first cycle; resp_valid[0]=1 exactly 4 cycles after issue, resp_data = model(0x11); inflight 1 → 0.
- All four requesters continuously valid, resp_ready=1 → issue order 0,1,2,3,0,1,…; resp_valid one-hot in the same order; 1 result/cycle; inflight saturates at 4.
- Backpressure: head belongs to req2 and resp_ready[2]=0 for 3 cycles → pipe_clk_en=0 and all req_ready=0 for those 3 cycles; tags and pipe_out hold; release → result delivered, next issue on the same edge.
- Pointer wrap, NUM_REQ=3: only req2 and req0 valid, rr_ptr=2 → grant 2 then 0, pointer ends at 1; requester 1 raised later is granted next.
- Reset mid-flight with inflight=3 and a stall active → next cycle resp_valid=0, pipe_clk_en=1, inflight=0; no stale responses after rst deasserts.
- Sparse traffic: requests 3 cycles apart → bubbles propagate; resp_valid pulses 1 cycle each, spaced 3 cycles, with correct ids.

Source files
------------

// File: rtl/pipe_sched_pkg.sv
// Shared types and helpers for the pipeline round-robin scheduler and its arbiters.
package pipe_sched_pkg;

  localparam int unsigned MAX_REQ = 16;

  function automatic int unsigned id_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Tag ids are sized for the largest supported requester count so one
  // struct type serves every instance; narrower ids are zero-extended.
  localparam int unsigned TAG_ID_W = id_w(MAX_REQ);

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } sched_tag_t;

endpackage

// File: rtl/pipe_rr_scheduler_if.sv
// Requester, pipeline and response signals of the shared-pipeline scheduler.
interface pipe_rr_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 4
);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           pipe_clk_en;
  logic [DATA_W-1:0]              pipe_in;
  logic [DATA_W-1:0]              pipe_out;
  logic [NUM_REQ-1:0]             resp_valid;
  logic [DATA_W-1:0]              resp_data;
  logic [NUM_REQ-1:0]             resp_ready;
  logic [CNT_W-1:0]               inflight;

  modport master (
    input  req_valid, req_data, pipe_out, resp_ready,
    output req_ready, pipe_clk_en, pipe_in, resp_valid, resp_data, inflight
  );

  modport slave (
    output req_valid, req_data, pipe_out, resp_ready,
    input  req_ready, pipe_clk_en, pipe_in, resp_valid, resp_data, inflight
  );

endinterface

// File: rtl/pipe_rr_scheduler_rr_grant.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_grant #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_idx
);

  logic           hi_found;
  logic           lo_found;
  logic [IDW-1:0] hi_idx;
  logic [IDW-1:0] lo_idx;

  // Two ascending scans replace a modulo search: the first hit at or above
  // ptr wins, otherwise the lowest hit overall is the wrapped winner.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (req[j] && !hi_found && (IDW'(j) >= ptr)) begin
        hi_found = 1'b1;
        hi_idx   = IDW'(j);
      end
      if (req[j] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = IDW'(j);
      end
    end
    grant_valid = lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/pipe_rr_scheduler.sv
// Round-robin front end for a shared fixed-latency clock-enabled pipeline;
// a tag line tracks requester ids so results return to their originators.
module pipe_rr_scheduler
  import pipe_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 4
) (
  input logic                 clk,
  input logic                 rst,
  pipe_rr_scheduler_if.master bus
);

  localparam int unsigned ID_W  = id_w(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  sched_tag_t         tag_q [LATENCY];
  sched_tag_t         tag_d [LATENCY];
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    rr_ptr_d;
  logic [CNT_W-1:0]   inflight_q;
  logic [CNT_W-1:0]   inflight_d;

  logic               grant_valid;
  logic [ID_W-1:0]    grant_idx;
  logic               stall;
  logic               issue;
  logic               consume;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] resp_valid;
  logic [DATA_W-1:0]  pipe_in;
  sched_tag_t         entry;

  rr_grant #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_rr_grant (
    .req         (bus.req_valid),
    .ptr         (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    resp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (tag_q[0].valid && (tag_q[0].id == TAG_ID_W'(i))) resp_valid[i] = 1'b1;
    end
    // Head present but its owner not accepting freezes the whole pipeline.
    stall   = |(resp_valid & ~bus.resp_ready);
    issue   = grant_valid & ~stall;
    consume = tag_q[0].valid & ~stall;

    req_ready = '0;
    pipe_in   = '0;
    entry     = '0;
    rr_ptr_d  = rr_ptr_q;
    if (issue) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (grant_idx == ID_W'(i)) begin
          req_ready[i] = 1'b1;
          pipe_in      = bus.req_data[i];
        end
      end
      entry.valid = 1'b1;
      entry.id    = TAG_ID_W'(grant_idx);
      rr_ptr_d    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end

    tag_d = tag_q;
    if (!stall) begin
      for (int unsigned i = 0; i + 1 < LATENCY; i++) tag_d[i] = tag_q[i+1];
      tag_d[LATENCY-1] = entry;
    end

    inflight_d = inflight_q;
    case ({issue, consume})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) tag_q[i] <= '0;
      rr_ptr_q   <= '0;
      inflight_q <= '0;
    end else begin
      tag_q      <= tag_d;
      rr_ptr_q   <= rr_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.pipe_clk_en = ~stall;
  assign bus.pipe_in     = pipe_in;
  assign bus.resp_valid  = resp_valid;
  assign bus.resp_data   = bus.pipe_out;
  assign bus.inflight    = inflight_q;

endmodule

// File: tb/tb_pipe_rr_scheduler.sv
// Bench for pipe_rr_scheduler: emulated shared pipeline, age-based reference
// model, randomized and directed scenarios.
module tb_pipe_rr_scheduler;

  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int LAT = 4;

  logic clk;
  logic rst;

  pipe_rr_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW), .LATENCY(LAT)) bus ();
  pipe_rr_scheduler_if #(.NUM_REQ(3), .DATA_W(8), .LATENCY(2)) bus3 ();

  pipe_rr_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipe_rr_scheduler #(.NUM_REQ(3), .DATA_W(8), .LATENCY(2)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pipe_f(input logic [31:0] x);
    return x * 32'd3 + 32'h5A;
  endfunction

  // Shared datapath stand-ins: first stage computes, the rest delay.
  logic [31:0] pst [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pst[i] <= '0;
    end else if (bus.pipe_clk_en) begin
      pst[0] <= pipe_f(bus.pipe_in);
      for (int i = 1; i < LAT; i++) pst[i] <= pst[i-1];
    end
  end
  assign bus.pipe_out = pst[LAT-1];

  logic [7:0] p3 [2];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p3[0] <= '0;
      p3[1] <= '0;
    end else if (bus3.pipe_clk_en) begin
      p3[0] <= bus3.pipe_in;
      p3[1] <= p3[0];
    end
  end
  assign bus3.pipe_out = p3[1];

  // Reference model: in-flight transactions with their enabled-edge age.
  typedef struct {
    int          id;
    logic [31:0] data;
    int          age;
  } item_t;

  item_t       m_q[$];
  int          m_ptr;
  int          m_issued;
  logic        e_head;
  logic        e_stall;
  int          e_grant;
  logic [3:0]  e_req_ready;
  logic        e_clk_en;
  logic [3:0]  e_resp_valid;
  logic [31:0] e_resp_data;
  int          e_inflight;

  int n_pass;
  int n_total;

  task automatic model_reset();
    m_q.delete();
    m_ptr    = 0;
    m_issued = -1;
  endtask

  task automatic model_eval();
    logic [3:0] rv;
    logic [3:0] rr;
    int         idx;
    rv = bus.req_valid;
    rr = bus.resp_ready;
    e_head = 1'b0;
    e_resp_valid = 4'd0;
    e_resp_data = 32'd0;
    if (m_q.size() > 0) begin
      if (m_q[0].age == LAT) begin
        e_head       = 1'b1;
        e_resp_valid = 4'(1 << m_q[0].id);
        e_resp_data  = m_q[0].data;
      end
    end
    e_stall = e_head && ((rr & e_resp_valid) == 4'd0);
    e_grant = -1;
    for (int k = 0; k < NR; k++) begin
      idx = (m_ptr + k) % NR;
      if (e_grant < 0 && ((rv >> idx) & 4'd1) != 4'd0) e_grant = idx;
    end
    e_req_ready = (e_grant >= 0 && !e_stall) ? 4'(1 << e_grant) : 4'd0;
    e_clk_en    = !e_stall;
    e_inflight  = m_q.size();
  endtask

  task automatic model_edge();
    logic [1:0] gi;
    item_t      it;
    m_issued = -1;
    if (!e_stall) begin
      if (e_head) void'(m_q.pop_front());
      foreach (m_q[j]) m_q[j].age = m_q[j].age + 1;
      if (e_grant >= 0) begin
        gi      = 2'(e_grant);
        it.id   = e_grant;
        it.data = pipe_f(bus.req_data[gi]);
        it.age  = 1;
        m_q.push_back(it);
        m_ptr    = (e_grant + 1) % NR;
        m_issued = e_grant;
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_eval();
  endtask

  task automatic at_pos();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_req(input logic [1:0] i, input logic [31:0] v);
    bus.req_data[i]  = v;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic drop_issued();
    logic [1:0] gi;
    if (m_issued >= 0) begin
      gi = 2'(m_issued);
      bus.req_valid[gi] = 1'b0;
    end
  endtask

  task automatic renew_issued();
    logic [1:0] gi;
    if (m_issued >= 0) begin
      gi = 2'(m_issued);
      bus.req_data[gi] = $urandom;
    end
  endtask

  task automatic drain();
    bus.req_valid  = '0;
    bus.resp_ready = '1;
    for (int t = 0; t < 12; t++) begin
      at_neg();
      if (e_inflight == 0) break;
      at_pos();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '0; bus.resp_ready = '1; bus.req_data = '0;
    bus3.req_valid = '0; bus3.resp_ready = '1; bus3.req_data = '0;
    repeat (2) @(negedge clk);
    n_total++; if (bus.resp_valid !== 4'd0) $display("FAIL reset_resp_valid got %b want 0000", bus.resp_valid); else n_pass++;
    n_total++; if (bus.pipe_clk_en !== 1'b1) $display("FAIL reset_clk_en got %b want 1", bus.pipe_clk_en); else n_pass++;
    n_total++; if (bus.inflight !== 3'd0) $display("FAIL reset_inflight got %0d want 0", bus.inflight); else n_pass++;
    bus.req_valid = 4'b0001;
    #1;
    n_total++; if (bus.req_ready !== 4'b0001) $display("FAIL reset_req_ready got %b want 0001", bus.req_ready); else n_pass++;
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_wrap3();
    logic [2:0] rv_t [9]  = '{3'b010, 3'b101, 3'b001, 3'b111, 3'b101, 3'b001, 3'b000, 3'b000, 3'b000};
    logic [2:0] rdy_t [9] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b000, 3'b000, 3'b000};
    logic [2:0] rsp_t [9] = '{3'b000, 3'b000, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b000};
    logic [7:0] dat_t [9] = '{8'h00, 8'h00, 8'hA1, 8'hB2, 8'hC0, 8'hD1, 8'hB2, 8'hC0, 8'h00};
    bus3.resp_ready = '1;
    bus3.req_data[0] = 8'hC0;
    bus3.req_data[1] = 8'hA1;
    bus3.req_data[2] = 8'hB2;
    for (int c = 0; c < 9; c++) begin
      if (c == 3) bus3.req_data[1] = 8'hD1;
      bus3.req_valid = rv_t[c];
      @(negedge clk);
      n_total++; if (bus3.req_ready !== rdy_t[c]) $display("FAIL wrap3_req_ready c%0d got %b want %b", c, bus3.req_ready, rdy_t[c]); else n_pass++;
      n_total++; if (bus3.resp_valid !== rsp_t[c]) $display("FAIL wrap3_resp_valid c%0d got %b want %b", c, bus3.resp_valid, rsp_t[c]); else n_pass++;
      if (rsp_t[c] != 3'b000) begin
        n_total++; if (bus3.resp_data !== dat_t[c]) $display("FAIL wrap3_resp_data c%0d got %h want %h", c, bus3.resp_data, dat_t[c]); else n_pass++;
      end
      @(posedge clk);
      #1;
    end
    n_total++; if (bus3.inflight !== 2'd0) $display("FAIL wrap3_inflight got %0d want 0", bus3.inflight); else n_pass++;
  endtask

  task automatic test_single();
    int seen_c;
    logic [31:0] seen_d;
    seen_c = -1;
    seen_d = '0;
    bus.resp_ready = '1;
    set_req(2'd0, 32'h11);
    at_neg();
    n_total++; if (bus.req_ready !== 4'b0001) $display("FAIL single_req_ready got %b want 0001", bus.req_ready); else n_pass++;
    at_pos();
    drop_issued();
    for (int c = 1; c <= 6; c++) begin
      at_neg();
      n_total++; if (bus.resp_valid !== e_resp_valid) $display("FAIL single_resp_valid c%0d got %b want %b", c, bus.resp_valid, e_resp_valid); else n_pass++;
      n_total++; if (bus.inflight !== 3'(e_inflight)) $display("FAIL single_inflight c%0d got %0d want %0d", c, bus.inflight, e_inflight); else n_pass++;
      if (bus.resp_valid[0] === 1'b1 && seen_c < 0) begin
        seen_c = c;
        seen_d = bus.resp_data;
      end
      at_pos();
    end
    n_total++; if (seen_c != 4) $display("FAIL single_latency got %0d want 4", seen_c); else n_pass++;
    n_total++; if (seen_d !== pipe_f(32'h11)) $display("FAIL single_data got %h want %h", seen_d, pipe_f(32'h11)); else n_pass++;
  endtask

  task automatic test_all_valid();
    int start;
    logic [3:0] want;
    start = m_ptr;
    bus.resp_ready = '1;
    for (int i = 0; i < NR; i++) set_req(2'(i), $urandom);
    for (int c = 0; c < 20; c++) begin
      at_neg();
      want = 4'(1 << ((start + c) % NR));
      n_total++; if (bus.req_ready !== want) $display("FAIL allv_order c%0d got %b want %b", c, bus.req_ready, want); else n_pass++;
      n_total++; if (bus.resp_valid !== e_resp_valid) $display("FAIL allv_resp_valid c%0d got %b want %b", c, bus.resp_valid, e_resp_valid); else n_pass++;
      if (c >= LAT) begin
        want = 4'(1 << ((start + c - LAT) % NR));
        n_total++; if (bus.resp_valid !== want) $display("FAIL allv_resp_order c%0d got %b want %b", c, bus.resp_valid, want); else n_pass++;
        n_total++; if (bus.resp_data !== e_resp_data) $display("FAIL allv_resp_data c%0d got %h want %h", c, bus.resp_data, e_resp_data); else n_pass++;
        n_total++; if (bus.inflight !== 3'd4) $display("FAIL allv_inflight c%0d got %0d want 4", c, bus.inflight); else n_pass++;
      end
      at_pos();
      renew_issued();
    end
  endtask

  task automatic test_backpressure();
    bit found;
    logic [31:0] hold;
    found = 1'b0;
    bus.resp_ready = '1;
    for (int t = 0; t < 8 && !found; t++) begin
      at_neg();
      if (e_resp_valid == 4'b0100) found = 1'b1;
      else begin
        at_pos();
        renew_issued();
      end
    end
    n_total++; if (!found) $display("FAIL bp_find_head got none want head of req2 within 8 cycles"); else n_pass++;
    if (found) begin
      bus.resp_ready = 4'b1011;
      #1;
      model_eval();
      hold = bus.pipe_out;
      for (int s = 0; s < 3; s++) begin
        n_total++; if (bus.pipe_clk_en !== 1'b0) $display("FAIL bp_clk_en s%0d got %b want 0", s, bus.pipe_clk_en); else n_pass++;
        n_total++; if (bus.req_ready !== 4'd0) $display("FAIL bp_req_ready s%0d got %b want 0000", s, bus.req_ready); else n_pass++;
        n_total++; if (bus.resp_valid !== 4'b0100) $display("FAIL bp_resp_valid s%0d got %b want 0100", s, bus.resp_valid); else n_pass++;
        n_total++; if (bus.pipe_out !== hold) $display("FAIL bp_hold s%0d got %h want %h", s, bus.pipe_out, hold); else n_pass++;
        n_total++; if (bus.inflight !== 3'(e_inflight)) $display("FAIL bp_inflight s%0d got %0d want %0d", s, bus.inflight, e_inflight); else n_pass++;
        at_pos();
        renew_issued();
        at_neg();
      end
      bus.resp_ready = '1;
      #1;
      model_eval();
      n_total++; if (bus.pipe_clk_en !== 1'b1) $display("FAIL bp_release_clk_en got %b want 1", bus.pipe_clk_en); else n_pass++;
      n_total++; if (bus.req_ready !== e_req_ready || bus.req_ready === 4'd0) $display("FAIL bp_release_issue got %b want %b", bus.req_ready, e_req_ready); else n_pass++;
      n_total++; if (bus.resp_data !== e_resp_data) $display("FAIL bp_release_data got %h want %h", bus.resp_data, e_resp_data); else n_pass++;
      at_pos();
      renew_issued();
    end
    drain();
  endtask

  task automatic test_sparse();
    int pulses[$];
    for (int c = 0; c < 27; c++) begin
      if (c % 3 == 0 && c < 18) set_req(2'($urandom_range(3)), $urandom);
      at_neg();
      n_total++; if (bus.resp_valid !== e_resp_valid) $display("FAIL sparse_resp_valid c%0d got %b want %b", c, bus.resp_valid, e_resp_valid); else n_pass++;
      if (e_resp_valid != 4'd0) begin
        n_total++; if (bus.resp_data !== e_resp_data) $display("FAIL sparse_resp_data c%0d got %h want %h", c, bus.resp_data, e_resp_data); else n_pass++;
      end
      if (bus.resp_valid !== 4'd0) pulses.push_back(c);
      at_pos();
      drop_issued();
    end
    n_total++; if (pulses.size() != 6) $display("FAIL sparse_pulse_count got %0d want 6", pulses.size()); else n_pass++;
    for (int k = 1; k < pulses.size(); k++) begin
      n_total++; if (pulses[k] - pulses[k-1] != 3) $display("FAIL sparse_spacing k%0d got %0d want 3", k, pulses[k] - pulses[k-1]); else n_pass++;
    end
  endtask

  task automatic test_random();
    int waits [NR];
    int max_wait;
    max_wait = 0;
    for (int i = 0; i < NR; i++) waits[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (bus.req_valid[2'(i)] === 1'b0 && $urandom_range(2) == 0) begin
          set_req(2'(i), $urandom);
          waits[i] = 0;
        end
      end
      bus.resp_ready = 4'($urandom) | 4'($urandom);
      at_neg();
      n_total++; if (bus.req_ready !== e_req_ready) $display("FAIL rand_req_ready c%0d got %b want %b", c, bus.req_ready, e_req_ready); else n_pass++;
      n_total++; if (bus.pipe_clk_en !== e_clk_en) $display("FAIL rand_clk_en c%0d got %b want %b", c, bus.pipe_clk_en, e_clk_en); else n_pass++;
      n_total++; if (bus.resp_valid !== e_resp_valid) $display("FAIL rand_resp_valid c%0d got %b want %b", c, bus.resp_valid, e_resp_valid); else n_pass++;
      n_total++; if (bus.inflight !== 3'(e_inflight)) $display("FAIL rand_inflight c%0d got %0d want %0d", c, bus.inflight, e_inflight); else n_pass++;
      if (e_resp_valid != 4'd0) begin
        n_total++; if (bus.resp_data !== e_resp_data) $display("FAIL rand_resp_data c%0d got %h want %h", c, bus.resp_data, e_resp_data); else n_pass++;
      end
      at_pos();
      if (m_issued >= 0) begin
        for (int i = 0; i < NR; i++) begin
          if (i != m_issued && bus.req_valid[2'(i)] === 1'b1) begin
            waits[i]++;
            if (waits[i] > max_wait) max_wait = waits[i];
          end
        end
        waits[m_issued] = 0;
      end
      drop_issued();
    end
    n_total++; if (max_wait > NR - 1) $display("FAIL rand_fairness got %0d want <= %0d", max_wait, NR - 1); else n_pass++;
    drain();
  endtask

  task automatic test_reset_midflight();
    bit found;
    found = 1'b0;
    bus.resp_ready = '0;
    for (int i = 0; i < 3; i++) set_req(2'(i), $urandom);
    for (int t = 0; t < 10 && !found; t++) begin
      at_neg();
      if (e_stall) found = 1'b1;
      else begin
        at_pos();
        drop_issued();
      end
    end
    n_total++; if (!found) $display("FAIL rmid_stall got none want stall within 10 cycles"); else n_pass++;
    n_total++; if (bus.inflight !== 3'd3) $display("FAIL rmid_inflight_pre got %0d want 3", bus.inflight); else n_pass++;
    rst = 1'b1;
    bus.req_valid = '0;
    #1;
    model_reset();
    n_total++; if (bus.resp_valid !== 4'd0) $display("FAIL rmid_resp_valid got %b want 0000", bus.resp_valid); else n_pass++;
    n_total++; if (bus.pipe_clk_en !== 1'b1) $display("FAIL rmid_clk_en got %b want 1", bus.pipe_clk_en); else n_pass++;
    n_total++; if (bus.inflight !== 3'd0) $display("FAIL rmid_inflight got %0d want 0", bus.inflight); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.resp_ready = '1;
    for (int c = 0; c < 8; c++) begin
      at_neg();
      n_total++; if (bus.resp_valid !== 4'd0) $display("FAIL rmid_stale c%0d got %b want 0000", c, bus.resp_valid); else n_pass++;
      n_total++; if (bus.inflight !== 3'd0) $display("FAIL rmid_after_inflight c%0d got %0d want 0", c, bus.inflight); else n_pass++;
      at_pos();
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    model_reset();
    test_reset();
    test_wrap3();
    test_single();
    test_all_valid();
    test_backpressure();
    test_sparse();
    test_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
